riscv_run_ctrl: RTL and testbench

- Synthesizable run controller for Procesador_RISC_V.
- Generates the core's reset pulse and counts cycles and retired instructions.
- Detects program completion (ECALL), timeout and PC hang, and reports pass/fail from the a0 (x10) register value.
- Sits beside the core in the top level, snooping its fetch and register-file write ports. It replaces fixed-delay run/stop sequencing with a decided, checkable end-of-run.

---
 rtl/riscv_run_pkg.sv | 10 +
 rtl/riscv_pc_hang_det.sv | 43 ++++
 rtl/riscv_run_ctrl.sv | 137 +++++++++++++
 tb/tb_riscv_run_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_run_pkg.sv
// Shared types and constants for the RISC-V run controller.
package riscv_run_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} run_state_t;
    typedef enum logic [1:0] {ST_OK, ST_A0_FAIL, ST_TIMEOUT, ST_HANG} run_status_t;

    localparam logic [31:0] ECALL_INSN = 32'h00000073;
    localparam logic [4:0]  A0_IDX     = 5'd10;

endpackage

// File: rtl/riscv_pc_hang_det.sv
// PC hang detector: counts consecutive valid fetches at an unchanged PC.
module riscv_pc_hang_det #(
    parameter int Bits        = 64,
    parameter int STALL_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic            inst_valid,
    input  logic [Bits-1:0] pc,
    output logic            hang
);

    localparam int RW = $clog2(STALL_LIMIT + 1);

    logic [Bits-1:0] last_pc;
    logic            last_vld;
    logic [RW-1:0]   rep;
    logic [RW-1:0]   rep_next;

    // The pulse is raised in the fetch that completes the run of repeats,
    // so the controller can stop on the following edge.
    always_comb begin
        rep_next = RW'(1);
        if (last_vld && pc == last_pc)
            rep_next = (rep == RW'(STALL_LIMIT)) ? rep : rep + RW'(1);
        hang = en && inst_valid && (rep_next == RW'(STALL_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
            rep      <= '0;
        end else if (en && inst_valid) begin
            last_pc  <= pc;
            last_vld <= 1'b1;
            rep      <= rep_next;
        end
    end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: core reset sequencing, cycle/retire counting and
// end-of-run detection (ECALL halt, PC hang, cycle-budget timeout).
module riscv_run_ctrl
    import riscv_run_pkg::*;
#(
    parameter int              Bits        = 64,
    parameter int              N           = 32,
    parameter int              RST_CYCLES  = 2,
    parameter int              MAX_CYCLES  = 64,
    parameter int              STALL_LIMIT = 8,
    parameter logic [N-1:0]    HALT_INSN   = N'(ECALL_INSN),
    localparam int             CW          = $clog2(MAX_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            inst_valid,
    input  logic [N-1:0]    inst,
    input  logic [Bits-1:0] pc,
    input  logic            rf_we,
    input  logic [4:0]      rf_waddr,
    input  logic [Bits-1:0] rf_wdata,
    output logic            core_rst,
    output logic            running,
    output logic            done,
    output logic            pass,
    output logic [1:0]      status,
    output logic [CW-1:0]   cycle_count,
    output logic [CW-1:0]   retired_count,
    output logic [Bits-1:0] a0_value
);

    localparam int HW = $clog2(RST_CYCLES + 1);

    run_state_t      state;
    run_status_t     st;
    logic [HW-1:0]   hold_cnt;
    logic [Bits-1:0] a0_shadow;
    logic [Bits-1:0] a0_next;
    logic            a0_wr;
    logic            halt;
    logic            timeout;
    logic            hang;
    logic            launch;

    assign status = st;

    always_comb begin
        a0_wr   = rf_we && (rf_waddr == A0_IDX);
        a0_next = a0_wr ? rf_wdata : a0_shadow;
        halt    = inst_valid && (inst == HALT_INSN);
        timeout = (cycle_count == CW'(MAX_CYCLES - 1));
        launch  = start && (state == IDLE || state == DONE);
    end

    riscv_pc_hang_det #(
        .Bits        (Bits),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_hang (
        .clk        (clk),
        .rst        (rst),
        .clr        (launch),
        .en         (state == RUN),
        .inst_valid (inst_valid),
        .pc         (pc),
        .hang       (hang)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            st            <= ST_OK;
            core_rst      <= 1'b1;
            running       <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            hold_cnt      <= '0;
            cycle_count   <= '0;
            retired_count <= '0;
            a0_shadow     <= '0;
            a0_value      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        state         <= HOLD;
                        st            <= ST_OK;
                        core_rst      <= 1'b1;
                        running       <= 1'b0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        hold_cnt      <= '0;
                        cycle_count   <= '0;
                        retired_count <= '0;
                        a0_shadow     <= '0;
                        a0_value      <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HW'(RST_CYCLES - 1)) begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RUN: begin
                    if (cycle_count != CW'(MAX_CYCLES))
                        cycle_count <= cycle_count + CW'(1);
                    if (inst_valid && retired_count != '1)
                        retired_count <= retired_count + CW'(1);
                    if (a0_wr)
                        a0_shadow <= rf_wdata;
                    // Halt outranks hang, which outranks timeout; a0 is
                    // captured with the same-cycle x10 write folded in.
                    if (halt || hang || timeout) begin
                        state    <= DONE;
                        core_rst <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        a0_value <= a0_next;
                        pass     <= halt && (a0_next == '0);
                        if (halt)
                            st <= (a0_next == '0) ? ST_OK : ST_A0_FAIL;
                        else if (hang)
                            st <= ST_HANG;
                        else
                            st <= ST_TIMEOUT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed and randomized runs of riscv_run_ctrl against a cycle-list model.
module tb_riscv_run_ctrl;

    localparam int MAXC  = 16;
    localparam int STALL = 8;
    localparam int CW    = $clog2(MAXC + 1);
    localparam logic [31:0] ECALL = 32'h00000073;

    logic        clk = 1'b0;
    logic        rst, start, inst_valid, rf_we;
    logic [31:0] inst;
    logic [63:0] pc, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        core_rst, running, done, pass;
    logic [1:0]  status;
    logic [CW-1:0] cycle_count, retired_count;
    logic [63:0] a0_value;

    riscv_run_ctrl #(
        .Bits        (64),
        .N           (32),
        .RST_CYCLES  (2),
        .MAX_CYCLES  (MAXC),
        .STALL_LIMIT (STALL),
        .HALT_INSN   (ECALL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .pc            (pc),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .core_rst      (core_rst),
        .running       (running),
        .done          (done),
        .pass          (pass),
        .status        (status),
        .cycle_count   (cycle_count),
        .retired_count (retired_count),
        .a0_value      (a0_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [63:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic        start;
    } stim_t;

    stim_t stim [MAXC];

    int n_checks = 0;
    int n_err    = 0;

    int unsigned exp_end;
    int unsigned exp_status;
    int unsigned exp_ret;
    logic [63:0] exp_a0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            stim[i].valid = 1'b1;
            stim[i].inst  = 32'h00000013;
            stim[i].pc    = 64'h1000 + 64'(4 * i);
            stim[i].we    = 1'b0;
            stim[i].waddr = 5'd0;
            stim[i].wdata = 64'd0;
            stim[i].start = 1'b0;
        end
    endtask

    task automatic set_wr(input int i, input logic [4:0] r, input logic [63:0] d);
        stim[i].we    = 1'b1;
        stim[i].waddr = r;
        stim[i].wdata = d;
    endtask

    // Reference: walk the per-cycle list and stop at the first cycle that
    // ends the run (halt first, then repeated-PC run, then budget).
    task automatic model();
        logic [63:0] a0, last;
        bit have_last;
        int unsigned reps;
        a0 = 0; have_last = 0; reps = 0; exp_ret = 0;
        exp_end = MAXC; exp_status = 2;
        for (int c = 1; c <= MAXC; c++) begin
            if (stim[c-1].we && stim[c-1].waddr == 5'd10) a0 = stim[c-1].wdata;
            if (stim[c-1].valid) begin
                exp_ret++;
                reps = (have_last && stim[c-1].pc == last) ? reps + 1 : 1;
                last = stim[c-1].pc;
                have_last = 1;
            end
            exp_a0 = a0;
            if (stim[c-1].valid && stim[c-1].inst == ECALL) begin
                exp_end = c; exp_status = (a0 == 0) ? 0 : 1; break;
            end else if (stim[c-1].valid && reps >= STALL) begin
                exp_end = c; exp_status = 3; break;
            end else if (c == MAXC) begin
                exp_end = c; exp_status = 2;
            end
        end
    endtask

    task automatic drive_idle();
        start = 0; inst_valid = 0; inst = 0; pc = 0;
        rf_we = 0; rf_waddr = 0; rf_wdata = 0;
    endtask

    task automatic drive(input int i);
        start      = stim[i].start;
        inst_valid = stim[i].valid;
        inst       = stim[i].inst;
        pc         = stim[i].pc;
        rf_we      = stim[i].we;
        rf_waddr   = stim[i].waddr;
        rf_wdata   = stim[i].wdata;
    endtask

    // Entered and left at #1 after a posedge. HOLD sees hostile core inputs
    // (ECALL, x10 write) that must have no effect.
    task automatic launch();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("hold1_core_rst", core_rst, 1);
        chk("hold1_running", running, 0);
        chk("hold1_done", done, 0);
        chk("hold1_status", status, 0);
        chk("hold1_cycles", cycle_count, 0);
        chk("hold1_retired", retired_count, 0);
        chk("hold1_a0", a0_value, 0);
        inst_valid = 1; inst = ECALL; rf_we = 1; rf_waddr = 5'd10; rf_wdata = 64'd99;
        @(posedge clk); #1;
        chk("hold2_core_rst", core_rst, 1);
        chk("hold2_running", running, 0);
        @(posedge clk); #1;
        chk("run_core_rst", core_rst, 0);
        chk("run_running", running, 1);
        chk("run_cycles0", cycle_count, 0);
    endtask

    task automatic run_check(input string name);
        model();
        launch();
        for (int k = 1; k <= int'(exp_end); k++) begin
            drive(k - 1);
            @(posedge clk); #1;
            if (k < int'(exp_end)) begin
                chk({name, "_busy"}, done, 0);
                chk({name, "_cyc"}, cycle_count, 64'(k));
            end
        end
        drive_idle();
        chk({name, "_done"}, done, 1);
        chk({name, "_running"}, running, 0);
        chk({name, "_core_rst"}, core_rst, 1);
        chk({name, "_status"}, status, 64'(exp_status));
        chk({name, "_pass"}, pass, 64'(exp_status == 0));
        chk({name, "_cycles"}, cycle_count, 64'(exp_end));
        chk({name, "_retired"}, retired_count, 64'(exp_ret));
        chk({name, "_a0"}, a0_value, exp_a0);
        inst_valid = 1; inst = ECALL; rf_we = 1; rf_waddr = 5'd10; rf_wdata = 64'd55;
        @(posedge clk); #1;
        drive_idle();
        chk({name, "_held_done"}, done, 1);
        chk({name, "_held_cycles"}, cycle_count, 64'(exp_end));
        chk({name, "_held_a0"}, a0_value, exp_a0);
    endtask

    initial begin
        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_status", status, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_retired", retired_count, 0);
        chk("rst_a0", a0_value, 0);

        clear_stim(); set_wr(0, 5'd10, 0); stim[6].inst = ECALL;
        run_check("clean_halt");

        clear_stim(); set_wr(1, 5'd10, 5); stim[3].inst = ECALL; set_wr(3, 5'd10, 0);
        run_check("bypass_zero");

        clear_stim(); set_wr(1, 5'd10, 5); stim[3].inst = ECALL; set_wr(3, 5'd10, 3);
        run_check("bypass_three");

        clear_stim(); set_wr(0, 5'd10, 0); set_wr(2, 5'd0, 7); set_wr(3, 5'd11, 9);
        stim[5].inst = ECALL;
        run_check("other_regs");

        clear_stim(); stim[3].start = 1; stim[9].start = 1; stim[4].valid = 0;
        stim[4].inst = ECALL;
        run_check("timeout");

        clear_stim(); set_wr(2, 5'd10, 1); stim[15].inst = ECALL;
        run_check("halt_last");

        clear_stim();
        for (int i = 0; i < STALL; i++) stim[i].pc = 64'h40;
        run_check("hang");

        clear_stim();
        for (int i = 0; i < STALL - 1; i++) stim[i].pc = 64'h40;
        stim[STALL-1].pc = 64'h44;
        run_check("no_hang");

        clear_stim();
        launch();
        for (int k = 0; k < 3; k++) begin
            drive(k);
            @(posedge clk); #1;
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        drive_idle();
        chk("abort_done", done, 0);
        chk("abort_core_rst", core_rst, 1);
        chk("abort_running", running, 0);
        chk("abort_cycles", cycle_count, 0);

        for (int r = 0; r < 12; r++) begin
            int unsigned mode;
            clear_stim();
            mode = $urandom_range(0, 2);
            for (int i = 0; i < MAXC; i++) begin
                stim[i].valid = ($urandom_range(0, 3) != 0);
                stim[i].inst  = $urandom;
                if (stim[i].inst == ECALL) stim[i].inst = 32'h00000013;
                if (!stim[i].valid && $urandom_range(0, 2) == 0) stim[i].inst = ECALL;
                stim[i].we    = $urandom_range(0, 1);
                case ($urandom_range(0, 3))
                    0:       stim[i].waddr = 5'd0;
                    1, 2:    stim[i].waddr = 5'd10;
                    default: stim[i].waddr = 5'($urandom);
                endcase
                stim[i].wdata = ($urandom_range(0, 1) != 0) ? 64'd0 : 64'($urandom_range(1, 9));
                stim[i].start = ($urandom_range(0, 7) == 0);
            end
            if (mode == 0) begin
                int unsigned h;
                h = $urandom_range(0, MAXC - 1);
                stim[h].valid = 1; stim[h].inst = ECALL;
            end else if (mode == 1) begin
                int unsigned s;
                s = $urandom_range(0, MAXC - STALL);
                for (int i = 0; i < STALL; i++) begin
                    stim[s + i].valid = 1;
                    stim[s + i].pc = 64'h40;
                end
            end
            run_check($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
